trsq_seq: RTL and testbench
===========================

# trsq_seq

Parametrised program sequencer for the next-generation TRSQ core. It replaces the fixed single-level PC/interrupt logic with a configurable-width program counter, an N-deep shared call/interrupt return stack, and a multi-channel prioritised interrupt controller. It sits between the instruction decoder and the program ROM address port. All state updates on the rising clock edge; there is no negedge logic.

## Interface
Parameters:
- PC_W, 13: program counter width.
- STACK_DEPTH, 4: return-stack entries, 1..16.
- IRQ_N, 4: interrupt channels, 1..8; channel 0 is highest priority.
- IRQ_VEC_BASE, 4: vector of channel 0.
- VEC_SHIFT, 1: vector spacing; channel c vector = IRQ_VEC_BASE + (c << VEC_SHIFT).

Ports:
- CLK_ip  in  1  clock.
- reset_ip  in  1  synchronous, active-high reset.
- jmp_ip  in  1  decoded jump.
- call_ip  in  1  decoded call (push, then jump).
- ret_ip  in  1  return from call.
- reti_ip  in  1  return from interrupt.
- skip_ip  in  1  skip condition already qualified by flags.
- halt_ip  in  1  decoded halt.
- tgt_ip  in  PC_W  jump/call target.
- irq_ip  in  IRQ_N  synchronous interrupt requests.
- irq_en_wr_ip  in  1  write enable mask.
- irq_en_din_ip  in  IRQ_N  new enable mask.
- pc_op  out  PC_W  program ROM address (registered).
- irq_pend_op  out  IRQ_N  pending bits.
- irq_isr_op  out  IRQ_N  in-service bits.
- ovf_op  out  1  sticky stack overflow.
- unf_op  out  1  sticky stack underflow.

## Operation
- Reset: pc_op=0, pending=0, in-service=0, enable mask=0, stack pointer=0, ovf_op=unf_op=0, edge-detect history=0.
- Pending: bit c set on a rising edge of irq_ip[c] (previous sample 0, current 1). Bit c cleared when channel c is taken; a new edge in the same cycle keeps it set.
- Eligible: pending & enable & priority gate. Without nesting, the gate is open only when in-service is all zero. Winner is the lowest-index eligible channel.
- Next-PC priority, one per cycle:
  1. reset.
  2. jmp/call/ret/reti: IRQ entry is deferred. Jump: pc=tgt. Call: push pc+1, pc=tgt. Ret: pop into pc. Reti: pop into pc and clear the lowest-index in-service bit.
  3. IRQ entry: push the return address, which is pc+2 if skip_ip else pc+1 (halt also pushes pc+1). Then pc=vector, set the in-service bit, clear the pending bit.
  4. halt: pc holds.
  5. skip: pc+2.
  6. otherwise pc+1.
- If more than one of jmp/call/ret/reti is asserted, the first in that order wins.
- Push when full: ovf_op set, entry dropped, PC still redirected.
- Pop when empty: unf_op set, pc=pc+1. Reti on empty still clears an in-service bit.
- PC arithmetic is modulo 2^PC_W and wraps from all-ones to 0.
- Enable write takes effect from the next cycle.

## Timing
- irq_ip rises before edge k: pending is set after edge k. If eligible, pc_op = vector after edge k+1. Latency is 2 cycles.
- Jump, call, ret, reti and skip affect pc_op after the same edge (1 cycle).
- ovf_op and unf_op assert after the offending edge and clear only on reset.
- Reset mid-ISR or mid-call discards the stack, pending and in-service state in one cycle.

## Configuration
- TRSQ_IRQ_NEST_EN defined: the priority gate opens for channel c when c is lower than the lowest set in-service index, so higher-priority channels preempt a running ISR. Entry pushes to the same stack.
- TRSQ_IRQ_NEST_EN undefined: there is no preemption, and pending requests wait until in-service is zero.

## Structure
- Package trsq_pkg holds:
  - next-PC select enum (RESET, JMP, CALL, RET, RETI, IRQ, HALT, SKIP, INC);
  - vector function;
  - lowest-set-bit priority encoder function.
- Sub-module trsq_pc_stack holds the LIFO with push, pop, data, full and empty, parametrised by PC_W and STACK_DEPTH.
- Top level holds the IRQ registers and next-PC mux.

## Test plan
- Reset, then 5 plain cycles: pc_op goes 0,1,2,3,4,5 and all flags are 0.
- call_ip with tgt=0x100 at pc=0x10, then ret_ip at 0x102: pc_op goes 0x100…0x102, then 0x11.
- Mask=0b0110. irq_ip[2] rises at pc=0x20, then irq_ip[1] rises one cycle later.
  - Unnested: vector 0x8, then after reti, vector 0x6.
  - Nested: vector 0x8, then preemption to 0x6.
- STACK_DEPTH=4 with 5 nested calls: ovf_op=1 after the 5th. Then 5 rets: the 5th sets unf_op=1 and gives pc+1.
- halt_ip at pc=0x30 with irq_ip[0] enabled: pc holds 0x30, then 0x4. After reti, pc=0x31.
- PC_W=4 at pc=0xF with plain execution: pc_op=0x0.

Source files
------------

// File: rtl/trsq_pkg.sv
// Shared types and helpers for the TRSQ program sequencer: next-PC select
// encoding, interrupt vector arithmetic and a lowest-set-bit encoder.
package trsq_pkg;

    typedef enum logic [3:0] {
        NPC_RESET,
        NPC_JMP,
        NPC_CALL,
        NPC_RET,
        NPC_RETI,
        NPC_IRQ,
        NPC_HALT,
        NPC_SKIP,
        NPC_INC
    } npc_sel_e;

    function automatic int irq_vector(int base, int shift, int ch);
        return base + (ch << shift);
    endfunction

    // Index of the lowest set bit; 0 when nothing is set (callers qualify).
    function automatic logic [2:0] lsb_index(logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/trsq_pc_stack.sv
// Return-address LIFO shared by calls and interrupt entry. A push when full
// and a pop when empty leave the contents untouched; the caller flags them.
module trsq_pc_stack
    import trsq_pkg::*;
#(
    parameter int PC_W        = 13,
    parameter int STACK_DEPTH = 4
) (
    input  logic            CLK_ip,
    input  logic            reset_ip,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            full,
    output logic            empty
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0]  mem [STACK_DEPTH];
    logic [SP_W-1:0]  sp;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;

    assign full    = (sp == SP_W'(STACK_DEPTH));
    assign empty   = (sp == '0);
    assign top_idx = IDX_W'(sp - SP_W'(1));
    assign wr_idx  = IDX_W'(sp);
    assign dout    = empty ? '0 : mem[top_idx];

    always_ff @(posedge CLK_ip) begin
        if (reset_ip) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    always_ff @(posedge CLK_ip) begin
        if (!reset_ip && push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/trsq_seq.sv
// TRSQ program sequencer: PC, return stack and prioritised interrupts.
// Define TRSQ_IRQ_NEST_EN to let higher-priority channels preempt an ISR.
module trsq_seq
    import trsq_pkg::*;
#(
    parameter int PC_W         = 13,
    parameter int STACK_DEPTH  = 4,
    parameter int IRQ_N        = 4,
    parameter int IRQ_VEC_BASE = 4,
    parameter int VEC_SHIFT    = 1
) (
    input  logic             CLK_ip,
    input  logic             reset_ip,
    input  logic             jmp_ip,
    input  logic             call_ip,
    input  logic             ret_ip,
    input  logic             reti_ip,
    input  logic             skip_ip,
    input  logic             halt_ip,
    input  logic [PC_W-1:0]  tgt_ip,
    input  logic [IRQ_N-1:0] irq_ip,
    input  logic             irq_en_wr_ip,
    input  logic [IRQ_N-1:0] irq_en_din_ip,
    output logic [PC_W-1:0]  pc_op,
    output logic [IRQ_N-1:0] irq_pend_op,
    output logic [IRQ_N-1:0] irq_isr_op,
    output logic             ovf_op,
    output logic             unf_op
);

    logic [IRQ_N-1:0] irq_prev, irq_en, rise, gate, elig, win_mask, isr_low_mask;
    logic [2:0]       win_idx;
    logic             irq_take;
    npc_sel_e         sel;
    logic [PC_W-1:0]  pc_inc1, pc_inc2, pc_next, push_data, stk_top, vec_pc;
    logic             push, pop, stk_full, stk_empty;

    assign rise         = irq_ip & ~irq_prev;
    assign pc_inc1      = pc_op + PC_W'(1);
    assign pc_inc2      = pc_op + PC_W'(2);
    assign elig         = irq_pend_op & irq_en & gate;
    assign irq_take     = |elig;
    assign win_idx      = lsb_index(8'(elig));
    assign win_mask     = IRQ_N'(1) << win_idx;
    assign isr_low_mask = IRQ_N'(1) << lsb_index(8'(irq_isr_op));
    assign vec_pc       = PC_W'(irq_vector(IRQ_VEC_BASE, VEC_SHIFT, int'(win_idx)));

    always_comb begin
        gate = '0;
`ifdef TRSQ_IRQ_NEST_EN
        // Channel c may preempt only if no in-service channel has index <= c.
        for (int c = 0; c < IRQ_N; c++) begin
            gate[c] = 1'b1;
            for (int j = 0; j <= c; j++) begin
                if (irq_isr_op[j]) gate[c] = 1'b0;
            end
        end
`else
        gate = {IRQ_N{irq_isr_op == '0}};
`endif
    end

    always_comb begin
        if (reset_ip)      sel = NPC_RESET;
        else if (jmp_ip)   sel = NPC_JMP;
        else if (call_ip)  sel = NPC_CALL;
        else if (ret_ip)   sel = NPC_RET;
        else if (reti_ip)  sel = NPC_RETI;
        else if (irq_take) sel = NPC_IRQ;
        else if (halt_ip)  sel = NPC_HALT;
        else if (skip_ip)  sel = NPC_SKIP;
        else               sel = NPC_INC;
    end

    always_comb begin
        pc_next   = pc_inc1;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = pc_inc1;
        case (sel)
            NPC_RESET: pc_next = '0;
            NPC_JMP:   pc_next = tgt_ip;
            NPC_CALL: begin
                push    = 1'b1;
                pc_next = tgt_ip;
            end
            NPC_RET, NPC_RETI: begin
                pop     = 1'b1;
                pc_next = stk_empty ? pc_inc1 : stk_top;
            end
            NPC_IRQ: begin
                push      = 1'b1;
                push_data = skip_ip ? pc_inc2 : pc_inc1;
                pc_next   = vec_pc;
            end
            NPC_HALT:  pc_next = pc_op;
            NPC_SKIP:  pc_next = pc_inc2;
            default:   pc_next = pc_inc1;
        endcase
    end

    trsq_pc_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .CLK_ip   (CLK_ip),
        .reset_ip (reset_ip),
        .push     (push),
        .pop      (pop),
        .din      (push_data),
        .dout     (stk_top),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    always_ff @(posedge CLK_ip) begin
        if (reset_ip) begin
            pc_op       <= '0;
            irq_prev    <= '0;
            irq_pend_op <= '0;
            irq_isr_op  <= '0;
            irq_en      <= '0;
            ovf_op      <= 1'b0;
            unf_op      <= 1'b0;
        end else begin
            pc_op    <= pc_next;
            irq_prev <= irq_ip;
            // A fresh edge on the channel being taken keeps it pending.
            irq_pend_op <= (irq_pend_op & ~((sel == NPC_IRQ) ? win_mask : '0)) | rise;
            if (sel == NPC_IRQ)       irq_isr_op <= irq_isr_op | win_mask;
            else if (sel == NPC_RETI) irq_isr_op <= irq_isr_op & ~isr_low_mask;
            if (irq_en_wr_ip) irq_en <= irq_en_din_ip;
            if (push && stk_full) ovf_op <= 1'b1;
            if (pop && stk_empty) unf_op <= 1'b1;
        end
    end

endmodule

// File: tb/tb_trsq_seq.sv
// Self-checking bench for trsq_seq: directed scenarios with fixed expectations
// plus randomized traffic compared against a queue-based reference model.
module tb_trsq_seq;

    localparam int PC_W         = 13;
    localparam int STACK_DEPTH  = 4;
    localparam int IRQ_N        = 4;
    localparam int IRQ_VEC_BASE = 4;
    localparam int VEC_SHIFT    = 1;
    localparam int unsigned PC_MASK = (1 << PC_W) - 1;

    logic             CLK_ip = 1'b0;
    logic             reset_ip, jmp_ip, call_ip, ret_ip, reti_ip, skip_ip, halt_ip;
    logic [PC_W-1:0]  tgt_ip;
    logic [IRQ_N-1:0] irq_ip;
    logic             irq_en_wr_ip;
    logic [IRQ_N-1:0] irq_en_din_ip;
    logic [PC_W-1:0]  pc_op;
    logic [IRQ_N-1:0] irq_pend_op, irq_isr_op;
    logic             ovf_op, unf_op;

    logic             jmp4;
    logic [3:0]       tgt4, pc4;
    logic [IRQ_N-1:0] pend4, isr4;
    logic             ovf4, unf4;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int unsigned      m_pc;
    int unsigned      m_stack[$];
    bit [IRQ_N-1:0]   m_pend, m_isr, m_en, m_prev;
    bit               m_ovf, m_unf;

    always #5 CLK_ip = ~CLK_ip;

    trsq_seq #(
        .PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH), .IRQ_N(IRQ_N),
        .IRQ_VEC_BASE(IRQ_VEC_BASE), .VEC_SHIFT(VEC_SHIFT)
    ) dut (
        .CLK_ip(CLK_ip), .reset_ip(reset_ip), .jmp_ip(jmp_ip), .call_ip(call_ip),
        .ret_ip(ret_ip), .reti_ip(reti_ip), .skip_ip(skip_ip), .halt_ip(halt_ip),
        .tgt_ip(tgt_ip), .irq_ip(irq_ip), .irq_en_wr_ip(irq_en_wr_ip),
        .irq_en_din_ip(irq_en_din_ip), .pc_op(pc_op), .irq_pend_op(irq_pend_op),
        .irq_isr_op(irq_isr_op), .ovf_op(ovf_op), .unf_op(unf_op)
    );

    trsq_seq #(.PC_W(4)) dut4 (
        .CLK_ip(CLK_ip), .reset_ip(reset_ip), .jmp_ip(jmp4), .call_ip(1'b0),
        .ret_ip(1'b0), .reti_ip(1'b0), .skip_ip(1'b0), .halt_ip(1'b0),
        .tgt_ip(tgt4), .irq_ip(4'b0), .irq_en_wr_ip(1'b0),
        .irq_en_din_ip(4'b0), .pc_op(pc4), .irq_pend_op(pend4),
        .irq_isr_op(isr4), .ovf_op(ovf4), .unf_op(unf4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mpush(input int unsigned v);
        if (m_stack.size() == STACK_DEPTH) m_ovf = 1'b1;
        else m_stack.push_back(v & PC_MASK);
    endtask

    // One clock of architectural behaviour, derived from the sequencer rules.
    task automatic model_update();
        int win, low;
        bit [IRQ_N-1:0] rise;
        if (reset_ip) begin
            m_pc = 0; m_pend = '0; m_isr = '0; m_en = '0; m_prev = '0;
            m_ovf = 1'b0; m_unf = 1'b0;
            m_stack.delete();
            return;
        end
        rise = irq_ip & ~m_prev;
        low = IRQ_N;
        for (int c = IRQ_N - 1; c >= 0; c--) if (m_isr[c]) low = c;
        win = -1;
        for (int c = IRQ_N - 1; c >= 0; c--) begin
`ifdef TRSQ_IRQ_NEST_EN
            if (m_pend[c] && m_en[c] && c < low) win = c;
`else
            if (m_pend[c] && m_en[c] && low == IRQ_N) win = c;
`endif
        end
        if (jmp_ip) begin
            m_pc = tgt_ip;
        end else if (call_ip) begin
            mpush(m_pc + 1);
            m_pc = tgt_ip;
        end else if (ret_ip || reti_ip) begin
            if (m_stack.size() == 0) begin
                m_unf = 1'b1;
                m_pc = m_pc + 1;
            end else begin
                m_pc = m_stack.pop_back();
            end
            if (!ret_ip && low < IRQ_N) m_isr[low] = 1'b0;
        end else if (win >= 0) begin
            mpush(skip_ip ? m_pc + 2 : m_pc + 1);
            m_pc = IRQ_VEC_BASE + (win << VEC_SHIFT);
            m_isr[win] = 1'b1;
            m_pend[win] = 1'b0;
        end else if (!halt_ip) begin
            m_pc = skip_ip ? m_pc + 2 : m_pc + 1;
        end
        m_pc = m_pc & PC_MASK;
        m_pend = m_pend | rise;
        if (irq_en_wr_ip) m_en = irq_en_din_ip;
        m_prev = irq_ip;
    endtask

    task automatic step();
        model_update();
        @(posedge CLK_ip);
        #1;
        chk("pc",   32'(pc_op),       m_pc);
        chk("pend", 32'(irq_pend_op), 32'(m_pend));
        chk("isr",  32'(irq_isr_op),  32'(m_isr));
        chk("ovf",  32'(ovf_op),      32'(m_ovf));
        chk("unf",  32'(unf_op),      32'(m_unf));
    endtask

    task automatic clr();
        jmp_ip = 0; call_ip = 0; ret_ip = 0; reti_ip = 0; skip_ip = 0; halt_ip = 0;
        irq_en_wr_ip = 0;
    endtask

    initial begin
        clr();
        reset_ip = 1; tgt_ip = '0; irq_ip = '0; irq_en_din_ip = '0;
        jmp4 = 0; tgt4 = '0;
        step();
        chk("rst_pc", 32'(pc_op), 0);
        chk("rst_flags", {ovf_op, unf_op, irq_pend_op, irq_isr_op}, 0);
        reset_ip = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("plain_pc", 32'(pc_op), i);
            chk("plain_flags", {ovf_op, unf_op}, 0);
        end

        // Narrow PC wraps from all-ones to zero
        jmp4 = 1; tgt4 = 4'hF;
        step();
        chk("w4_at_f", 32'(pc4), 32'hF);
        jmp4 = 0;
        step();
        chk("w4_wrap", 32'(pc4), 0);
        chk("w4_flags", {ovf4, unf4, pend4, isr4}, 0);

        // Call / return
        jmp_ip = 1; tgt_ip = 13'h010; step(); jmp_ip = 0;
        call_ip = 1; tgt_ip = 13'h100; step(); call_ip = 0;
        chk("call_tgt", 32'(pc_op), 32'h100);
        step(); step();
        chk("in_sub", 32'(pc_op), 32'h102);
        ret_ip = 1; step(); ret_ip = 0;
        chk("ret_pc", 32'(pc_op), 32'h11);

        // Two requests, channel 2 first then channel 1
        irq_en_wr_ip = 1; irq_en_din_ip = 4'b0110; jmp_ip = 1; tgt_ip = 13'h020;
        step(); clr();
        chk("at_20", 32'(pc_op), 32'h20);
        irq_ip = 4'b0100; step();
        chk("pend2", 32'(irq_pend_op), 32'b0100);
        irq_ip = 4'b0110; step();
        chk("vec2", 32'(pc_op), 32'h8);
        chk("isr2", 32'(irq_isr_op), 32'b0100);
`ifdef TRSQ_IRQ_NEST_EN
        step();
        chk("preempt_vec1", 32'(pc_op), 32'h6);
        chk("isr21", 32'(irq_isr_op), 32'b0110);
        reti_ip = 1; step();
        chk("reti_inner", 32'(pc_op), 32'h9);
        step();
        chk("reti_outer", 32'(pc_op), 32'h22);
        reti_ip = 0;
`else
        step();
        chk("no_preempt", 32'(pc_op), 32'h9);
        reti_ip = 1; step(); reti_ip = 0;
        chk("reti_pc", 32'(pc_op), 32'h22);
        chk("reti_isr", 32'(irq_isr_op), 0);
        step();
        chk("vec1", 32'(pc_op), 32'h6);
        reti_ip = 1; step(); reti_ip = 0;
        chk("reti1_pc", 32'(pc_op), 32'h23);
`endif
        irq_ip = '0; step();

        // Overflow after five nested calls, underflow on the fifth return
        reset_ip = 1; step(); reset_ip = 0;
        call_ip = 1; tgt_ip = 13'h040;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 4) chk("no_ovf_yet", 32'(ovf_op), 0);
        end
        call_ip = 0;
        chk("ovf_set", 32'(ovf_op), 1);
        ret_ip = 1;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 4) begin
                chk("ret4_pc", 32'(pc_op), 32'h1);
                chk("no_unf_yet", 32'(unf_op), 0);
            end
        end
        ret_ip = 0;
        chk("unf_set", 32'(unf_op), 1);
        chk("unf_pc", 32'(pc_op), 32'h2);

        // Halt with channel 0 pending
        reset_ip = 1; step(); reset_ip = 0;
        irq_en_wr_ip = 1; irq_en_din_ip = 4'b0001; jmp_ip = 1; tgt_ip = 13'h030;
        step(); clr();
        halt_ip = 1; irq_ip = 4'b0001; step();
        chk("halt_hold", 32'(pc_op), 32'h30);
        step();
        chk("halt_vec0", 32'(pc_op), 32'h4);
        halt_ip = 0; reti_ip = 1; step(); reti_ip = 0;
        chk("halt_ret", 32'(pc_op), 32'h31);
        skip_ip = 1; step(); skip_ip = 0;
        chk("skip_pc", 32'(pc_op), 32'h33);

        // Reset in the middle of an ISR discards stack and interrupt state
        irq_ip = '0; step();
        irq_ip = 4'b0001; step(); step();
        chk("isr0_in", 32'(pc_op), 32'h4);
        reset_ip = 1; step(); reset_ip = 0;
        chk("rst_isr", 32'(irq_isr_op), 0);
        reti_ip = 1; irq_ip = '0; step(); reti_ip = 0;
        chk("rst_stack_empty", 32'(unf_op), 1);
        chk("rst_unf_pc", 32'(pc_op), 32'h1);

        // Randomized traffic against the model
        reset_ip = 1; step(); reset_ip = 0;
        for (int n = 0; n < 800; n++) begin
            reset_ip      = ($urandom_range(99) == 0);
            jmp_ip        = ($urandom_range(19) == 0);
            call_ip       = ($urandom_range(11) == 0);
            ret_ip        = ($urandom_range(15) == 0);
            reti_ip       = ($urandom_range(13) == 0);
            skip_ip       = ($urandom_range(9) == 0);
            halt_ip       = ($urandom_range(19) == 0);
            tgt_ip        = PC_W'($urandom);
            if ($urandom_range(3) == 0) irq_ip = irq_ip ^ IRQ_N'($urandom);
            irq_en_wr_ip  = ($urandom_range(11) == 0);
            irq_en_din_ip = IRQ_N'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
